// File: rtl/inv_shift_rows_unit.sv
// AES (Inv)ShiftRows unit with valid/ready handshake; rows rotated serially or in one cycle.
// Optional forward-rotation select is compiled in with `define SHIFT_ROWS_FWD_EN.
module inv_shift_rows_unit #(
    parameter int unsigned SINGLE_CYCLE = 0
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
`ifdef SHIFT_ROWS_FWD_EN
    input  logic         fwdSel,
`endif
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   row_cnt_q, row_cnt_d;
    logic [127:0] work_q, work_d;
    logic         live_q, live_d;
    logic         fwd_op;

`ifdef SHIFT_ROWS_FWD_EN
    logic fwd_q, fwd_d;
    assign fwd_op = fwd_q;
`else
    assign fwd_op = 1'b0;
`endif

    // Rotate row r of a column-major state: right by r bytes, or left when fwd is set.
    function automatic logic [127:0] rot_row(input logic [127:0] s, input int unsigned r,
                                             input logic fwd);
        logic [127:0] o;
        o = s;
        for (int unsigned c = 0; c < 4; c++) begin
            int unsigned src;
            src = fwd ? ((c + r) % 4) : ((c + 4 - r) % 4);
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
        end
        return o;
    endfunction

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        work_d    = work_q;
        live_d    = 1'b1;
`ifdef SHIFT_ROWS_FWD_EN
        fwd_d     = fwd_q;
`endif
        if (flush) begin
            state_d   = IDLE;
            row_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid && inReady) begin
                        work_d    = inState;
                        row_cnt_d = 2'd1;
                        state_d   = BUSY;
`ifdef SHIFT_ROWS_FWD_EN
                        fwd_d     = fwdSel;
`endif
                    end
                end
                BUSY: begin
                    if (SINGLE_CYCLE != 0) begin
                        work_d    = rot_row(rot_row(rot_row(work_q, 1, fwd_op), 2, fwd_op),
                                            3, fwd_op);
                        row_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        // row_cnt wraps 3 -> 0 as the last row completes
                        work_d    = rot_row(work_q, 32'(row_cnt_q), fwd_op);
                        row_cnt_d = row_cnt_q + 2'd1;
                        if (row_cnt_q == 2'd3) state_d = DONE;
                    end
                end
                DONE: begin
                    if (outReady) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            work_q    <= '0;
            live_q    <= 1'b0;
`ifdef SHIFT_ROWS_FWD_EN
            fwd_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            work_q    <= work_d;
            live_q    <= live_d;
`ifdef SHIFT_ROWS_FWD_EN
            fwd_q     <= fwd_d;
`endif
        end
    end

    // live_q holds inReady low until the first edge after reset release
    assign inReady  = live_q && (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign outState = work_q;

endmodule
